mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage load/store controller; sits between the EX/MEM pipeline register and the word-wide data memory (dm).
// - Drives dm address/data_in/mem_write and consumes dm data_out (dm samples writes on posedge, updates data_out on negedge).
// - Word ops complete in 1 cycle; byte/halfword stores use a 2-cycle read-modify-write with pipeline stall.
// - Loads are lane-extracted and sign/zero-extended.
// PARAMETERS
// - ADDR_W   32  request/dm address width
// - DATA_W   32  word width; fixed at 32, other values unsupported
// PORTS
// - clock         in   1   single clock, rising edge
// - reset         in   1   synchronous, active-high
// - req_valid     in   1   EX/MEM holds a memory op this cycle
// - req_op        in   4   mem_op_t code (package)
// - req_addr      in   32  byte address
// - req_wdata     in   32  store data; low byte/half used for SB/SH
// - stall         out  1   combinational; upstream must hold req_* stable while high
// - load_valid    out  1   registered; pulses 1 cycle after an accepted load
// - load_data     out  32  registered extended load result
// - misalign      out  1   registered fault pulse (MISALIGN_TRAP_EN only)
// - dm_address    out  32  to dm address
// - dm_data_in    out  32  to dm data_in
// - dm_mem_write  out  1   to dm mem_write
// - dm_data_out   in   32  from dm data_out
// BEHAVIOUR
// - Reset: state=IDLE, load_valid=0, load_data=0, misalign=0, rd_buf=0; dm_mem_write=0 while reset is high.
// - Byte lanes little-endian: lane = addr[1:0]; half lane = addr[1].
// - FSM: IDLE, RMW_WR.
// - IDLE, no req_valid or OP_NONE: dm_mem_write=0, dm_address=req_addr, stall=0.
// - IDLE + SW: dm_mem_write=1, dm_data_in=req_wdata; completes same cycle; stall=0.
// - IDLE + load: dm_mem_write=0; at posedge capture dm_data_out, extract/extend -> load_data, load_valid=1 next cycle.
// - LB/LH sign-extend, LBU/LHU zero-extend.
// - IDLE + SB/SH: stall=1, dm_mem_write=0, word read; posedge: rd_buf<=dm_data_out, ->RMW_WR.
// - RMW_WR: stall=0, dm_mem_write=1, dm_data_in = rd_buf with target lane(s) replaced by req_wdata; ->IDLE.
// - In RMW_WR the held req is not re-decoded; the next IDLE cycle carries the next instruction.
// - dm_address = {req_addr[31:2],2'b00} for every op.
// - load_valid is a 1-cycle pulse; load_data holds its value until the next load.
// - Reset mid-RMW: next state IDLE, no write issued, rd_buf cleared.
// - Undefined op codes are treated as OP_NONE.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0: no dm write, no load_valid, stall=0.
//   - misalign pulses 1 cycle later.
// - Undefined: misalign tied 0; low address bits ignored; half ops use addr[1], word ops ignore addr[1:0].
// STRUCTURE
// - Package mem_pkg: mem_op_t (OP_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8), state_t, helper functions is_load/is_store/is_sub_store.
// - One sub-module: load_extract (combinational lane select + sign/zero extend), reused by WB-stage forwarding.
// TESTING
// - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> load_valid next cycle, load_data=0xDEADBEEF, stall never high.
// - Word 0x11223344 at 0x20; SB addr 0x21 data 0xAA -> stall 1 cycle, then word=0x1122AA44.
// - LB 0x22 of 0x1180_3344 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x22 -> 0x00001180.
// - SH addr 0x22 data 0xBEEF over 0x11223344 -> 0xBEEF3344; back-to-back SW in next cycle is accepted and written.
// - reset asserted during RMW_WR -> memory word unchanged, state IDLE, stall 0 next cycle.
// - MISALIGN_TRAP_EN: LW 0x13 -> misalign=1 next cycle, load_valid=0; SW 0x12 -> memory unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and op-class helpers for the MEM-stage load/store path.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    LB      = 4'd1,
    LBU     = 4'd2,
    LH      = 4'd3,
    LHU     = 4'd4,
    LW      = 4'd5,
    SB      = 4'd6,
    SH      = 4'd7,
    SW      = 4'd8
  } mem_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Raw 4-bit codes are decoded here so undefined values fall out as no-ops.
  function automatic logic is_load(input logic [3:0] op);
    case (op)
      LB, LBU, LH, LHU, LW: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      SB, SH, SW: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_store(input logic [3:0] op);
    case (op)
      SB, SH:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    case (op)
      LH, LHU, SH: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    case (op)
      LW, SW:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational little-endian lane select with sign/zero extension for loads.
module load_extract
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = '0;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
  end

  // Half lane is chosen by lane[1] only; lane[0] is a don't-care for halves.
  assign half_s = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (op)
      LB:      data = {{(DATA_W-8){byte_s[7]}}, byte_s};
      LBU:     data = {{(DATA_W-8){1'b0}}, byte_s};
      LH:      data = {{(DATA_W-16){half_s[15]}}, half_s};
      LHU:     data = {{(DATA_W-16){1'b0}}, half_s};
      LW:      data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller with 2-cycle read-modify-write for SB/SH.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  output logic              dm_mem_write,
  input  logic [DATA_W-1:0] dm_data_out
);

  state_t            state, state_nxt;
  logic [3:0]        op_p0;
  logic              misal_p0;
  logic              take_load_p0;
  logic              take_rmw_p0;
  logic [DATA_W-1:0] ld_ext_p0;
  logic [DATA_W-1:0] rd_buf;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [3:0]        op,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] r;
    r = old;
    if (op == SB) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (op == SH) begin
      if (lane[1]) r[31:16] = wd[15:0];
      else         r[15:0]  = wd[15:0];
    end
    return r;
  endfunction

  // Stage p0: decode the request held in EX/MEM
  assign op_p0 = req_valid ? req_op : 4'(OP_NONE);

`ifdef MISALIGN_TRAP_EN
  assign misal_p0 = (is_half(op_p0) && req_addr[0]) ||
                    (is_word(op_p0) && (req_addr[1:0] != 2'b00));
`else
  assign misal_p0 = 1'b0;
`endif

  assign take_load_p0 = (state == IDLE) && is_load(op_p0) && !misal_p0;
  assign take_rmw_p0  = (state == IDLE) && is_sub_store(op_p0) && !misal_p0;
  assign dm_address   = {req_addr[ADDR_W-1:2], 2'b00};

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .op   (op_p0),
    .lane (req_addr[1:0]),
    .word (dm_data_out),
    .data (ld_ext_p0)
  );

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    dm_mem_write = 1'b0;
    dm_data_in   = req_wdata;
    case (state)
      IDLE: begin
        if (!misal_p0) begin
          if (op_p0 == SW) begin
            dm_mem_write = 1'b1;
          end else if (is_sub_store(op_p0)) begin
            stall     = 1'b1;
            state_nxt = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // Held request is not re-decoded; it only supplies lane and data.
        dm_mem_write = 1'b1;
        dm_data_in   = merge_lanes(req_op, req_addr[1:0], rd_buf, req_wdata);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      dm_mem_write = 1'b0;
      state_nxt    = IDLE;
    end
  end

  // Stage p1: registered load result and RMW read buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      load_valid <= 1'b0;
      load_data  <= '0;
      rd_buf     <= '0;
    end else begin
      state      <= state_nxt;
      load_valid <= take_load_p0;
      if (take_load_p0) load_data <= ld_ext_p0;
      if (take_rmw_p0)  rd_buf    <= dm_data_out;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= (state == IDLE) && misal_p0;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide data memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic [31:0] dm_address;
  logic [31:0] dm_data_in;
  logic        dm_mem_write;
  logic [31:0] dm_data_out;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;
  int st, st2;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign     (misalign),
    .dm_address   (dm_address),
    .dm_data_in   (dm_data_in),
    .dm_mem_write (dm_mem_write),
    .dm_data_out  (dm_data_out)
  );

  always #5 clock = ~clock;

  // Data memory: writes on rising edge, read port refreshes on falling edge.
  always @(posedge clock) if (dm_mem_write) mem[dm_address[7:2]] <= dm_data_in;
  always @(negedge clock) dm_data_out <= mem[dm_address[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one request, holding it while stall is high; returns stall cycles.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output int stalls);
    logic s;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    stalls    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s = stall;
      @(posedge clock);
      #1;
      if (!s) break;
      stalls++;
    end
    if (stalls >= 4) chk("stall_timeout", 32'(stalls), 32'd1);
    req_valid = 1'b0;
    req_op    = 4'(OP_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = 4'(SW);
    req_addr  = 32'h10;
    req_wdata = 32'h12345678;
    @(negedge clock);
    chk("rst_no_write", dm_mem_write, 1'b0);
    @(posedge clock); #1;
    chk("rst_load_valid", load_valid, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'(OP_NONE);
    @(negedge clock);
    chk("idle_stall", stall, 1'b0);
    chk("idle_addr", dm_address, 32'h10);
    @(posedge clock); #1;

    // Word store then word load
    issue(4'(SW), 32'h10, 32'hDEADBEEF, st);
    chk("sw_stall", 32'(st), 32'd0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_no_lv", load_valid, 1'b0);
    issue(4'(LW), 32'h10, 32'h0, st);
    chk("lw_stall", 32'(st), 32'd0);
    chk("lw_valid", load_valid, 1'b1);
    chk("lw_data", load_data, 32'hDEADBEEF);
    @(posedge clock); #1;
    chk("lv_pulse", load_valid, 1'b0);
    chk("ld_hold", load_data, 32'hDEADBEEF);

    // Byte store read-modify-write; upper wdata bits must be ignored
    issue(4'(SW), 32'h20, 32'h11223344, st);
    issue(4'(SB), 32'h21, 32'h123456AA, st);
    chk("sb_stall", 32'(st), 32'd1);
    chk("sb_mem", mem[8], 32'h1122AA44);

    // Lane extraction and extension
    issue(4'(SW), 32'h20, 32'h11803344, st);
    issue(4'(LB), 32'h22, 32'h0, st);
    chk("lb_22", load_data, 32'hFFFFFF80);
    issue(4'(LBU), 32'h22, 32'h0, st);
    chk("lbu_22", load_data, 32'h00000080);
    issue(4'(LH), 32'h22, 32'h0, st);
    chk("lh_22", load_data, 32'h00001180);
    issue(4'(LH), 32'h20, 32'h0, st);
    chk("lh_20", load_data, 32'h00003344);
    issue(4'(LB), 32'h23, 32'h0, st);
    chk("lb_23", load_data, 32'h00000011);
    issue(4'(SW), 32'h24, 32'h8001F00F, st);
    issue(4'(LH), 32'h26, 32'h0, st);
    chk("lh_26", load_data, 32'hFFFF8001);
    issue(4'(LHU), 32'h26, 32'h0, st);
    chk("lhu_26", load_data, 32'h00008001);
    issue(4'(LH), 32'h24, 32'h0, st);
    chk("lh_24", load_data, 32'hFFFFF00F);

    // Halfword RMW followed immediately by a word store
    issue(4'(SW), 32'h20, 32'h11223344, st);
    issue(4'(SH), 32'h22, 32'hFFFFBEEF, st);
    issue(4'(SW), 32'h28, 32'hCAFEF00D, st2);
    chk("sh_stall", 32'(st), 32'd1);
    chk("sh_mem", mem[8], 32'hBEEF3344);
    chk("sw_b2b_stall", 32'(st2), 32'd0);
    chk("sw_b2b_mem", mem[10], 32'hCAFEF00D);
    issue(4'(SH), 32'h20, 32'h00005555, st);
    chk("sh_lo_mem", mem[8], 32'hBEEF5555);

    // Reset while in the RMW write cycle
    issue(4'(SW), 32'h30, 32'h55667788, st);
    req_valid = 1'b1;
    req_op    = 4'(SB);
    req_addr  = 32'h30;
    req_wdata = 32'h00000099;
    @(negedge clock);
    chk("rmw_stall", stall, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_rmw_nowr", dm_mem_write, 1'b0);
    @(posedge clock); #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'(OP_NONE);
    chk("rst_rmw_mem", mem[12], 32'h55667788);
    @(negedge clock);
    chk("rst_rmw_stall", stall, 1'b0);
    @(posedge clock); #1;
    issue(4'(LW), 32'h30, 32'h0, st);
    chk("rst_rmw_lv", load_valid, 1'b1);
    chk("rst_rmw_ld", load_data, 32'h55667788);

    // Undefined op code and deasserted valid behave as no-ops
    req_valid = 1'b1;
    req_op    = 4'hF;
    req_addr  = 32'h30;
    req_wdata = 32'h0;
    @(negedge clock);
    chk("undef_wr", dm_mem_write, 1'b0);
    chk("undef_stall", stall, 1'b0);
    @(posedge clock); #1;
    chk("undef_lv", load_valid, 1'b0);
    req_valid = 1'b0;
    req_op    = 4'(SW);
    @(negedge clock);
    chk("novalid_wr", dm_mem_write, 1'b0);
    @(posedge clock); #1;
    req_op = 4'(OP_NONE);

`ifdef MISALIGN_TRAP_EN
    issue(4'(LW), 32'h13, 32'h0, st);
    chk("mis_lw_flag", misalign, 1'b1);
    chk("mis_lw_lv", load_valid, 1'b0);
    @(posedge clock); #1;
    chk("mis_pulse", misalign, 1'b0);
    issue(4'(SW), 32'h12, 32'h0BADF00D, st);
    chk("mis_sw_flag", misalign, 1'b1);
    chk("mis_sw_mem", mem[4], 32'hDEADBEEF);
    issue(4'(SH), 32'h21, 32'h00001234, st);
    chk("mis_sh_stall", 32'(st), 32'd0);
    chk("mis_sh_mem", mem[8], 32'hBEEF5555);
`else
    issue(4'(LW), 32'h13, 32'h0, st);
    chk("lw_13_lv", load_valid, 1'b1);
    chk("lw_13_data", load_data, 32'hDEADBEEF);
    chk("lw_13_mis", misalign, 1'b0);
    issue(4'(SW), 32'h12, 32'h0BADF00D, st);
    chk("sw_12_mem", mem[4], 32'h0BADF00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
